// File: rtl/slave_master_pkg.sv
// rtl/slave_master_pkg.sv - shared constants, SPI mode enum and register-bank contents
package slave_master_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 8;
  localparam int NUM_SLAVES = 4;
  localparam int REG_DEPTH  = 16;
  localparam int IDX_BITS   = $clog2(REG_DEPTH);
  localparam int CNT_BITS   = 5;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  function automatic logic [DATA_BITS-1:0] reg_init(input logic [3:0]          slave,
                                                    input logic [IDX_BITS-1:0] idx);
    return {slave, idx};
  endfunction

endpackage

// File: rtl/slave_master_if.sv
// rtl/slave_master_if.sv - shared SPI bus: four active-low selects, mode pins, MOSI/MISO
interface slave_master_if;

  logic ss1;
  logic ss2;
  logic ss3;
  logic ss4;
  logic cpol;
  logic cpoh;
  logic MOSI;
  logic MISO;

  modport slave (
    input  ss1, ss2, ss3, ss4, cpol, cpoh, MOSI,
    output MISO
  );

  modport master (
    output ss1, ss2, ss3, ss4, cpol, cpoh, MOSI,
    input  MISO
  );

endinterface

// File: rtl/slave_master_spi_slave_core.sv
// rtl/slave_master_spi_slave_core.sv - one SPI slave: bit counter, address shifter, read-only bank
module spi_slave_core
  import slave_master_pkg::*;
#(
  parameter int SLAVE_ID = 1
) (
  input  logic sck,
  input  logic rst,
  input  logic ss_n,
  input  logic cpol,
  input  logic cpoh,
  input  logic mosi,
  output logic miso
);

  localparam logic [CNT_BITS-1:0] ADDR_LAST  = CNT_BITS'(ADDR_BITS - 1);
  localparam logic [CNT_BITS-1:0] FRAME_LAST = CNT_BITS'(FRAME_BITS - 1);
  localparam logic [CNT_BITS-1:0] ADDR_LEN   = CNT_BITS'(ADDR_BITS);

  spi_mode_t mode;
  logic      samp_clk;
  logic      clr;

  logic [CNT_BITS-1:0]  cnt_q,   cnt_d;
  logic [ADDR_BITS-1:0] addr_q,  addr_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 miso_q,  miso_d;

  // Sampling happens on rising samp_clk in every mode; MISO updates on its falling edge.
  assign mode     = spi_mode_t'({cpol, cpoh});
  assign samp_clk = (mode == MODE1 || mode == MODE2) ? ~sck : sck;
  assign clr      = rst | ss_n;

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    if (cnt_q < ADDR_LEN) begin
      addr_d = {mosi, addr_q[ADDR_BITS-1:1]};
    end
    if (cnt_q == ADDR_LAST) begin
      shift_d = reg_init(4'(SLAVE_ID), addr_d[IDX_BITS-1:0]);
    end
    cnt_d = (cnt_q >= FRAME_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter values 8..15 at a drive edge select data bits 0..7.
  always_comb begin
    miso_d = 1'b0;
    if (cnt_q[4:3] == 2'b01) begin
      miso_d = shift_q[cnt_q[2:0]];
    end
  end

  always_ff @(posedge samp_clk or posedge clr) begin
    if (clr) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(negedge samp_clk or posedge clr) begin
    if (clr) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/slave_master.sv
// rtl/slave_master.sv - four-slave SPI cluster; select priority and MISO mux (MISO_TRISTATE_EN)
module slave_master
  import slave_master_pkg::*;
(
  input  logic           sck,
  input  logic           reset,
  slave_master_if.slave  bus
);

  logic [NUM_SLAVES-1:0] ss_n;
  logic [NUM_SLAVES-1:0] miso_s;
  logic                  any_sel;
  logic                  miso_mux;

  assign ss_n = {bus.ss4, bus.ss3, bus.ss2, bus.ss1};

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
    spi_slave_core #(
      .SLAVE_ID (g + 1)
    ) u_core (
      .sck  (sck),
      .rst  (reset),
      .ss_n (ss_n[g]),
      .cpol (bus.cpol),
      .cpoh (bus.cpoh),
      .mosi (bus.MOSI),
      .miso (miso_s[g])
    );
  end

  // Walk from the lowest priority upward so ss1 overrides the rest.
  always_comb begin
    miso_mux = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (!ss_n[i]) begin
        miso_mux = miso_s[i];
      end
    end
  end

  assign any_sel = ~&ss_n;

`ifdef MISO_TRISTATE_EN
  assign bus.MISO = any_sel ? miso_mux : 1'bz;
`else
  assign bus.MISO = any_sel ? miso_mux : 1'b0;
`endif

endmodule

// File: tb/tb_slave_master.sv
// tb/tb_slave_master.sv - bit-banged SPI master with reference model for slave_master
module tb_slave_master;

  localparam time H = 5;

  logic sck;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  slave_master_if bus();

  slave_master dut (
    .sck   (sck),
    .reset (reset),
    .bus   (bus)
  );

`ifdef MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  // Reference: first low select wins; slave n answers {n, addr[3:0]} in the last 8 bits.
  function automatic logic [15:0] model(input logic [3:0] ss_n, input logic [15:0] fr);
    int n;
    n = 0;
    for (int i = 3; i >= 0; i--) begin
      if (!ss_n[i]) n = i + 1;
    end
    return {4'(n), fr[3:0], 8'h00};
  endfunction

  task automatic xfer(input logic [1:0] m, input logic [3:0] ss_n, input logic [15:0] fr,
                      input int nbits, input bit release_ss, output logic [15:0] rx);
    rx = '0;
    bus.cpol = m[1];
    bus.cpoh = m[0];
    sck = m[1];
    #H;
    {bus.ss4, bus.ss3, bus.ss2, bus.ss1} = ss_n;
    #H;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        bus.MOSI = fr[i];
        #H;
        rx[i] = bus.MISO;
        sck = ~m[1];
        #H;
        sck = m[1];
      end else begin
        sck = ~m[1];
        bus.MOSI = fr[i];
        #H;
        rx[i] = bus.MISO;
        sck = m[1];
        #H;
      end
    end
    #H;
    if (release_ss) {bus.ss4, bus.ss3, bus.ss2, bus.ss1} = 4'hF;
    #H;
  endtask

  task automatic run_check(input string name, input logic [1:0] m, input logic [3:0] ss_n,
                           input logic [15:0] fr);
    logic [15:0] rx;
    logic [15:0] exp;
    exp = model(ss_n, fr);
    xfer(m, ss_n, fr, 16, 1'b1, rx);
    checks++;
    if (rx !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, rx, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #H;
    checks++;
    if (bus.MISO !== IDLE_MISO) begin
      errors++;
      $display("FAIL reset_idle_miso: got %b expected %b", bus.MISO, IDLE_MISO);
    end
    bus.ss2 = 1'b0;
    #H;
    checks++;
    if (bus.MISO !== 1'b0) begin
      errors++;
      $display("FAIL reset_selected_miso: got %b expected 0", bus.MISO);
    end
    bus.ss2 = 1'b1;
    reset = 1'b0;
    #H;
  endtask

  task automatic test_modes();
    logic [15:0] rx;
    run_check("mode0_ss2_0002", 2'b00, 4'b1101, 16'h0002);
    run_check("mode1_ss2_001e", 2'b01, 4'b1101, 16'h001E);
    run_check("mode2_ss2_0032", 2'b10, 4'b1101, 16'h0032);
    run_check("mode3_ss2_0005", 2'b11, 4'b1101, 16'h0005);
    xfer(2'b00, 4'b1101, 16'h0002, 16, 1'b1, rx);
    checks++;
    if (rx !== 16'h2200) begin
      errors++;
      $display("FAIL mode0_literal: got %h expected 2200", rx);
    end
  endtask

  task automatic test_priority();
    run_check("prio_ss1_ss3", 2'b00, 4'b1010, 16'h0007);
    run_check("prio_ss3_ss4", 2'b11, 4'b0011, 16'h00A9);
    run_check("prio_ss4_only", 2'b01, 4'b0111, 16'h000F);
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    xfer(2'b00, 4'b1101, 16'h03FF, 10, 1'b0, rx);
    reset = 1'b1;
    #H;
    reset = 1'b0;
    #H;
    run_check("reset_abort_0003", 2'b00, 4'b1101, 16'h0003);
    xfer(2'b01, 4'b1011, 16'h00FF, 5, 1'b1, rx);
    run_check("deselect_abort_000c", 2'b01, 4'b1011, 16'h000C);
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx;
    xfer(2'b10, 4'b1110, 16'h0004, 16, 1'b0, rx);
    checks++;
    if (rx !== model(4'b1110, 16'h0004)) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", rx, model(4'b1110, 16'h0004));
    end
    xfer(2'b10, 4'b1110, 16'h000B, 16, 1'b1, rx);
    checks++;
    if (rx !== model(4'b1110, 16'h000B)) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", rx, model(4'b1110, 16'h000B));
    end
  endtask

  task automatic test_random();
    logic [1:0]  m;
    logic [3:0]  ss_n;
    logic [15:0] fr;
    for (int k = 0; k < 24; k++) begin
      m    = 2'($urandom_range(0, 3));
      ss_n = 4'($urandom_range(0, 14));
      fr   = 16'($urandom);
      run_check($sformatf("random_%0d", k), m, ss_n, fr);
    end
  endtask

  task automatic test_idle();
    {bus.ss4, bus.ss3, bus.ss2, bus.ss1} = 4'hF;
    #H;
    checks++;
    if (bus.MISO !== IDLE_MISO) begin
      errors++;
      $display("FAIL idle_miso: got %b expected %b", bus.MISO, IDLE_MISO);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sck = 1'b0;
    reset = 1'b0;
    bus.ss1 = 1'b1;
    bus.ss2 = 1'b1;
    bus.ss3 = 1'b1;
    bus.ss4 = 1'b1;
    bus.cpol = 1'b0;
    bus.cpoh = 1'b0;
    bus.MOSI = 1'b0;
    #H;
    test_reset();
    test_modes();
    test_priority();
    test_abort();
    test_back_to_back();
    test_random();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
